// File: rtl/keypad_entry_controller_if.sv
// Request/response bundle between the keypad entry controller and the downstream ALU.
interface keypad_entry_controller_if #(
  parameter int WIDTH = 16
);
  logic             calc_valid;
  logic             calc_ready;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;

  modport master (
    output calc_valid, opcode, operand_a, operand_b,
    input  calc_ready, result
  );

  modport slave (
    input  calc_valid, opcode, operand_a, operand_b,
    output calc_ready, result
  );
endinterface

// File: rtl/keypad_entry_controller.sv
// Hex calculator front end: collects two operands and an operator from keypresses,
// hands the request to an external ALU and shows/chains the returned result.
module keypad_entry_controller #(
  parameter int WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      newkey,
  input  logic [4:0]                keycode,
  keypad_entry_controller_if.master calc,
  output logic [WIDTH-1:0]          display,
  output logic                      digit_dropped,
  output logic                      busy
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, REQ, SHOW} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] opa, opa_nx, opb, opb_nx;
  logic [1:0]       opc, opc_nx;
  logic             valid, valid_nx, drop, drop_nx;

  logic             is_digit, is_eq, is_op, is_clr, is_bksp;
  logic [1:0]       key_op;
  logic [3:0]       d;
  logic [WIDTH-1:0] cur, shifted;

  assign d        = keycode[3:0];
  assign is_digit = newkey && keycode[4];
  assign is_eq    = newkey && (keycode == 5'b00100);
  assign is_clr   = newkey && (keycode == 5'b00001);
  assign is_bksp  = newkey && (keycode == 5'b00010);

  always_comb begin
    is_op  = 1'b0;
    key_op = 2'b00;
    if (newkey) begin
      case (keycode)
        5'b01011: begin is_op = 1'b1; key_op = 2'b00; end
        5'b01010: begin is_op = 1'b1; key_op = 2'b01; end
        5'b01100: begin is_op = 1'b1; key_op = 2'b10; end
        default:  begin is_op = 1'b0; key_op = 2'b00; end
      endcase
    end
  end

  // The operand currently being typed is A in ENTRY_A and B in ENTRY_B.
  assign cur     = (state == ENTRY_B) ? opb : opa;
  assign shifted = {cur[WIDTH-5:0], d};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    opa_nx   = opa;
    opb_nx   = opb;
    opc_nx   = opc;
    valid_nx = valid;
    drop_nx  = 1'b0;
    case (state)
      ENTRY_A, ENTRY_B: begin
        if (is_clr) begin
          state_nx = ENTRY_A;
          cnt_nx   = '0;
          opa_nx   = '0;
          opb_nx   = '0;
          opc_nx   = 2'b00;
        end else if (is_digit) begin
          if (cnt == FULL) begin
            drop_nx = 1'b1;
          end else begin
            if (state == ENTRY_A) opa_nx = shifted;
            else                  opb_nx = shifted;
            // Leading zeros do not consume display capacity.
            if (!(cur == '0 && d == 4'd0)) cnt_nx = cnt + CW'(1);
          end
        end else if (is_bksp) begin
          if (cnt != '0) begin
            if (state == ENTRY_A) opa_nx = cur >> 4;
            else                  opb_nx = cur >> 4;
            cnt_nx = cnt - CW'(1);
          end
        end else if (is_op) begin
          if (state == ENTRY_A) begin
            opc_nx   = key_op;
            opb_nx   = '0;
            cnt_nx   = '0;
            state_nx = ENTRY_B;
          end else if (cnt == '0) begin
            opc_nx = key_op;
          end
        end else if (is_eq && state == ENTRY_B) begin
          if (cnt == '0) opb_nx = opa;
          valid_nx = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (valid && calc.calc_ready) begin
          opa_nx   = calc.result;
          valid_nx = 1'b0;
          cnt_nx   = '0;
          state_nx = SHOW;
        end
      end
      SHOW: begin
        if (is_clr) begin
          state_nx = ENTRY_A;
          cnt_nx   = '0;
          opa_nx   = '0;
          opb_nx   = '0;
          opc_nx   = 2'b00;
        end else if (is_digit) begin
          opa_nx   = {{(WIDTH-4){1'b0}}, d};
          cnt_nx   = (d != 4'd0) ? CW'(1) : '0;
          state_nx = ENTRY_A;
        end else if (is_op) begin
          opc_nx   = key_op;
          opb_nx   = '0;
          cnt_nx   = '0;
          state_nx = ENTRY_B;
        end else if (is_eq) begin
          valid_nx = 1'b1;
          state_nx = REQ;
        end
      end
      default: state_nx = ENTRY_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ENTRY_A;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      opc   <= 2'b00;
      valid <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      opa   <= opa_nx;
      opb   <= opb_nx;
      opc   <= opc_nx;
      valid <= valid_nx;
      drop  <= drop_nx;
    end
  end

  assign calc.calc_valid = valid;
  assign calc.opcode     = opc;
  assign calc.operand_a  = opa;
  assign calc.operand_b  = opb;

  assign display       = (state == ENTRY_B && cnt != '0) ? opb : opa;
  assign digit_dropped = drop;
  assign busy          = (state == REQ);

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Randomized and directed bench for keypad_entry_controller; an abstract calculator
// model predicts outputs and a scoreboard checks every ALU handshake.
module tb_keypad_entry_controller;

  localparam int WIDTH  = 16;
  localparam int DIGITS = WIDTH / 4;
  localparam logic [4:0] KEQ  = 5'b00100;
  localparam logic [4:0] KADD = 5'b01011;
  localparam logic [4:0] KSUB = 5'b01010;
  localparam logic [4:0] KMUL = 5'b01100;
  localparam logic [4:0] KCLR = 5'b00001;
  localparam logic [4:0] KBS  = 5'b00010;
  localparam int MA = 0, MB = 1, MR = 2, MS = 3;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } req_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        newkey;
  logic [4:0]  keycode;
  logic [15:0] display;
  logic        digit_dropped;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  req_t expq[$];
  req_t mon_e;

  int          m_mode;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_op;
  logic        m_drop;

  keypad_entry_controller_if #(.WIDTH(WIDTH)) calc();

  keypad_entry_controller #(.WIDTH(WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .newkey        (newkey),
    .keycode       (keycode),
    .calc          (calc),
    .display       (display),
    .digit_dropped (digit_dropped),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every accepted request must match the oldest predicted one.
  always @(negedge clock) begin
    if (!reset && calc.calc_valid === 1'b1 && calc.calc_ready === 1'b1) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_request: got handshake, expected none");
      end else begin
        mon_e = expq.pop_front();
        checkVal("req_opcode", 32'(calc.opcode), 32'(mon_e.op));
        checkVal("req_operand_a", 32'(calc.operand_a), 32'(mon_e.a));
        checkVal("req_operand_b", 32'(calc.operand_b), 32'(mon_e.b));
      end
    end
  end

  function automatic int ndig(input logic [15:0] v);
    int n = 0;
    int x = int'(v);
    while (x != 0) begin
      x = x / 16;
      n++;
    end
    return n;
  endfunction

  function automatic int opOf(input logic [4:0] k);
    if (k == KADD) return 0;
    if (k == KSUB) return 1;
    if (k == KMUL) return 2;
    return -1;
  endfunction

  task automatic modelClear();
    m_mode = MA;
    m_a    = '0;
    m_b    = '0;
    m_op   = 2'b00;
    m_drop = 1'b0;
  endtask

  // Calculator behaviour: an operand's digit count is simply its significant hex digits.
  task automatic modelKey(input logic [4:0] k);
    logic [15:0] cur;
    int opv;
    m_drop = 1'b0;
    opv = opOf(k);
    if (m_mode == MR) return;
    if (k == KCLR) begin
      modelClear();
      return;
    end
    if (m_mode == MS) begin
      if (k[4]) begin
        m_a = 16'(k[3:0]);
        m_mode = MA;
      end else if (opv >= 0) begin
        m_op = 2'(opv);
        m_b = '0;
        m_mode = MB;
      end else if (k == KEQ) begin
        expq.push_back('{op: m_op, a: m_a, b: m_b});
        m_mode = MR;
      end
      return;
    end
    cur = (m_mode == MA) ? m_a : m_b;
    if (k[4]) begin
      if (ndig(cur) < DIGITS) cur = 16'(cur * 16 + k[3:0]);
      else m_drop = 1'b1;
    end else if (k == KBS) begin
      cur = cur / 16;
    end else if (opv >= 0) begin
      if (m_mode == MA) begin
        m_op = 2'(opv);
        m_b = '0;
        m_mode = MB;
        return;
      end else if (m_b == 0) begin
        m_op = 2'(opv);
      end
    end else if (k == KEQ && m_mode == MB) begin
      if (m_b == 0) m_b = m_a;
      expq.push_back('{op: m_op, a: m_a, b: m_b});
      m_mode = MR;
      return;
    end
    if (m_mode == MA) m_a = cur;
    else m_b = cur;
  endtask

  task automatic checkOutput(input string tag);
    logic [15:0] exp_disp;
    exp_disp = (m_mode == MB && m_b != 0) ? m_b : m_a;
    checkVal({tag, "_display"}, 32'(display), 32'(exp_disp));
    checkVal({tag, "_calc_valid"}, 32'(calc.calc_valid), 32'(m_mode == MR));
    checkVal({tag, "_busy"}, 32'(busy), 32'(m_mode == MR));
    checkVal({tag, "_digit_dropped"}, 32'(digit_dropped), 32'(m_drop));
    checkVal({tag, "_operand_a"}, 32'(calc.operand_a), 32'(m_a));
    checkVal({tag, "_operand_b"}, 32'(calc.operand_b), 32'(m_b));
    checkVal({tag, "_opcode"}, 32'(calc.opcode), 32'(m_op));
  endtask

  task automatic applyStimulus(input logic [4:0] k);
    @(posedge clock);
    #1;
    newkey  = 1'b1;
    keycode = k;
    @(posedge clock);
    #1;
    newkey  = 1'b0;
    keycode = 5'($urandom);
    modelKey(k);
    checkOutput("key");
  endtask

  task automatic idleCycle();
    @(posedge clock);
    #1;
    m_drop = 1'b0;
    checkOutput("idle");
  endtask

  function automatic logic [4:0] randKey();
    int r;
    logic [4:0] junk [10];
    junk = '{5'd0, 5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd13, 5'd14, 5'd15};
    r = $urandom_range(0, 19);
    if (r <= 9) return {1'b1, 4'($urandom_range(0, 15))};
    if (r <= 11) return KEQ;
    if (r == 12) return KADD;
    if (r == 13) return KSUB;
    if (r == 14) return KMUL;
    if (r == 15) return ($urandom_range(0, 2) == 0) ? KCLR : KBS;
    if (r <= 17) return KBS;
    return junk[$urandom_range(0, 9)];
  endfunction

  // Plays the ALU: stall for a while (optionally pressing keys), then accept.
  task automatic serviceRequest(input int waitc, input logic [15:0] res, input bit poke);
    for (int i = 0; i < waitc; i++) begin
      if (poke) begin
        newkey  = 1'b1;
        keycode = ($urandom_range(0, 3) == 0) ? KCLR : randKey();
      end
      @(posedge clock);
      #1;
      newkey = 1'b0;
      m_drop = 1'b0;
      checkOutput("stall");
    end
    calc.calc_ready = 1'b1;
    calc.result     = res;
    @(posedge clock);
    #1;
    calc.calc_ready = 1'b0;
    calc.result     = 16'($urandom);
    m_a    = res;
    m_mode = MS;
    m_drop = 1'b0;
    checkOutput("accept");
  endtask

  initial begin
    reset           = 1'b1;
    newkey          = 1'b0;
    keycode         = 5'd0;
    calc.calc_ready = 1'b0;
    calc.result     = '0;
    modelClear();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset");
    reset = 1'b0;

    applyStimulus(5'h11);
    applyStimulus(5'h12);
    applyStimulus(KADD);
    applyStimulus(5'h13);
    applyStimulus(KEQ);
    serviceRequest(0, 16'h0015, 1'b0);
    idleCycle();

    applyStimulus(KCLR);
    applyStimulus(5'h11);
    applyStimulus(5'h12);
    applyStimulus(KADD);
    applyStimulus(5'h13);
    applyStimulus(KEQ);
    serviceRequest(1, 16'h0010, 1'b0);
    applyStimulus(KEQ);
    serviceRequest(2, 16'h0013, 1'b0);

    applyStimulus(KCLR);
    for (int i = 1; i <= 5; i++) applyStimulus({1'b1, 4'(i)});
    idleCycle();
    applyStimulus(KBS);

    applyStimulus(KCLR);
    applyStimulus(5'h10);
    applyStimulus(5'h10);
    applyStimulus(5'h15);
    for (int i = 6; i <= 9; i++) applyStimulus({1'b1, 4'(i)});

    applyStimulus(KCLR);
    applyStimulus(5'h17);
    applyStimulus(KMUL);
    applyStimulus(KEQ);
    serviceRequest(5, 16'h0031, 1'b1);

    applyStimulus(KCLR);
    applyStimulus(KEQ);
    applyStimulus(KBS);
    applyStimulus(5'h15);
    applyStimulus(KADD);
    applyStimulus(KSUB);
    applyStimulus(5'h12);
    applyStimulus(KMUL);
    applyStimulus(KEQ);
    serviceRequest(0, 16'hBEEF, 1'b0);
    applyStimulus(KADD);
    applyStimulus(5'h11);
    applyStimulus(KEQ);
    serviceRequest(1, 16'h1234, 1'b0);
    applyStimulus(5'h1A);

    // Withdraw a pending request with a key arriving on the same edge.
    applyStimulus(KCLR);
    applyStimulus(5'h13);
    applyStimulus(KADD);
    applyStimulus(KEQ);
    reset   = 1'b1;
    newkey  = 1'b1;
    keycode = 5'h19;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    newkey = 1'b0;
    modelClear();
    expq.delete();
    checkOutput("mid_reset");
    idleCycle();

    for (int n = 0; n < 400; n++) begin
      applyStimulus(randKey());
      if (m_mode == MR)
        serviceRequest($urandom_range(0, 3), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clock);
    #1;
    checkVal("pending_requests", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_entry_controller.md
KEYPAD_ENTRY_CONTROLLER -- requirements
Module: keypad_entry_controller

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant DIGITS = WIDTH/4 SHALL be the maximum hex digits per operand.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 newkey  input  1  high for one cycle per new keypress.
REQ-006 keycode  input  5  key pressed; sampled only when newkey=1.
REQ-007 calc_ready  input  1  downstream ALU accepts request.
REQ-008 result  input  WIDTH  ALU result; valid in the cycle calc_valid=1 and calc_ready=1.
REQ-009 calc_valid  output  1  request to ALU.
REQ-010 opcode  output  2  00 add, 01 subtract, 10 multiply, 11 unused.
REQ-011 operand_a  output  WIDTH  first operand / last result.
REQ-012 operand_b  output  WIDTH  second operand.
REQ-013 display  output  WIDTH  value for the hex display.
REQ-014 digit_dropped  output  1  one-cycle pulse when a digit is rejected for capacity.
REQ-015 busy  output  1  high while a request is outstanding.

Function
REQ-016 Key decode: keycode[4]=1 -> hex digit keycode[3:0]; 5'b00100 equals; 5'b01011 add; 5'b01010 subtract; 5'b01100 multiply; 5'b00001 clear; 5'b00010 backspace; all other codes SHALL be ignored.
REQ-017 States: ENTRY_A, ENTRY_B, REQ, SHOW; a digit counter cnt (0..DIGITS) SHALL track digits in the operand being entered.
REQ-018 Digit in ENTRY_A/ENTRY_B, cnt<DIGITS: operand <= {operand[WIDTH-5:0], d}; cnt increments unless operand==0 and d==0 (leading zeros not counted).
REQ-019 Digit with cnt==DIGITS: operand unchanged; digit_dropped=1 for exactly the next cycle.
REQ-020 Backspace in ENTRY_A/ENTRY_B: operand <= operand>>4, cnt decrements; at cnt==0 no effect. Ignored in SHOW.
REQ-021 Operator in ENTRY_A: latch opcode, clear operand_b, cnt<=0, go ENTRY_B.
REQ-022 Operator in ENTRY_B with cnt==0: replace opcode, stay; with cnt>0: ignored.
REQ-023 Equals in ENTRY_A: ignored.
REQ-024 Equals in ENTRY_B: if cnt==0 then operand_b <= operand_a on the same edge; go REQ.
REQ-025 In REQ, calc_valid=1 and operand_a, operand_b, opcode SHALL remain stable until the cycle calc_ready=1.
REQ-026 On calc_valid=1 and calc_ready=1: operand_a <= result, calc_valid <= 0, go SHOW; operand_b and opcode retained.
REQ-027 All newkey events while in REQ SHALL be ignored, including clear.
REQ-028 SHOW: digit -> operand_a <= {0,d}, cnt <= (d!=0), go ENTRY_A; operator -> as REQ-021 (chain on result); equals -> go REQ repeating last opcode and operand_b.
REQ-029 Clear in ENTRY_A/ENTRY_B/SHOW SHALL apply the reset values of REQ-033 on the next edge.
REQ-030 display = operand_b in ENTRY_B when cnt>0, otherwise operand_a.
REQ-031 busy = (state==REQ); calc_valid SHALL be registered, asserted the cycle after the equals edge.
REQ-032 The module performs no arithmetic; result SHALL be taken unmodified, WIDTH bits.

Reset
REQ-033 reset=1 at a rising edge SHALL force state ENTRY_A, cnt=0, operand_a=0, operand_b=0, opcode=00, calc_valid=0, digit_dropped=0, busy=0, regardless of state, including mid-REQ (request withdrawn).
REQ-034 newkey coincident with reset SHALL be ignored.

Verification (WIDTH=16)
REQ-035 Keys 1,2,add,3,equals, calc_ready=1 with result=0x0015 -> calc_valid 1 for one cycle, operand_a=0x0012, operand_b=0x0003, opcode=00; then display=0x0015, state SHOW.
REQ-036 Digits 1,2,3,4,5 -> operand_a=0x1234, digit_dropped pulses once on the fifth key; backspace -> 0x0123.
REQ-037 Keys 7,multiply,equals with calc_ready held 0 for 5 cycles, interleaved keys -> calc_valid stays 1, operands 0x0007/0x0007 stable, keys ignored; accept on ready.
REQ-038 From SHOW with result 0x0010, equals again (last op add, operand_b=0x0003) -> new request operand_a=0x0010, operand_b=0x0003, opcode=00.
REQ-039 Keys 0,0,5 -> operand_a=0x0005, cnt=1; then 4 more digits -> one digit_dropped.
REQ-040 reset asserted while calc_valid=1 -> next cycle calc_valid=0, all outputs at REQ-033 values.
